// File: rtl/hls_call_sequencer_if.sv
// Bundle of run-control, argument-stream, accelerator and result-stream signals.
// The master modport is the sequencer's view; slave is the host/accelerator side.
interface hls_call_sequencer_if #(
   parameter int ARG_W = 32,
   parameter int RET_W = 32,
   parameter int CNT_W = 32
);
   logic             run_start;
   logic [CNT_W-1:0] num_calls;
   logic             run_busy;
   logic             run_done;
   logic             timeout_err;

   logic             arg_valid;
   logic             arg_ready;
   logic [ARG_W-1:0] arg_data;

   logic             acc_start;
   logic             acc_ready;
   logic             acc_finish;
   logic [ARG_W-1:0] acc_arg;
   logic [RET_W-1:0] acc_return_val;

   logic             res_valid;
   logic             res_ready;
   logic [RET_W-1:0] res_data;
   logic [CNT_W-1:0] res_latency;

   logic [CNT_W-1:0] calls_done;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      input  run_start, num_calls, arg_valid, arg_data,
             acc_ready, acc_finish, acc_return_val, res_ready,
      output run_busy, run_done, timeout_err, arg_ready,
             acc_start, acc_arg, res_valid, res_data, res_latency,
             calls_done, cycle_count
   );

   modport slave (
      output run_start, num_calls, arg_valid, arg_data,
             acc_ready, acc_finish, acc_return_val, res_ready,
      input  run_busy, run_done, timeout_err, arg_ready,
             acc_start, acc_arg, res_valid, res_data, res_latency,
             calls_done, cycle_count
   );
endinterface

// File: rtl/hls_call_sequencer.sv
// Drives an HLS start/ready/finish accelerator once per popped argument, streams
// each return value with its latency, and tracks run statistics with a watchdog.
module hls_call_sequencer #(
   parameter int ARG_W   = 32,
   parameter int RET_W   = 32,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   hls_call_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);

   state_e           state_q;
   logic [CNT_W-1:0] num_calls_q;
   logic [CNT_W-1:0] calls_done_q;
   logic [CNT_W-1:0] cycle_count_q;
   logic [CNT_W-1:0] latency_q;
   logic [CNT_W-1:0] res_latency_q;
   logic [ARG_W-1:0] acc_arg_q;
   logic [RET_W-1:0] res_data_q;
   logic             run_busy_q;
   logic             run_done_q;
   logic             timeout_err_q;
   logic             arg_ready_q;
   logic             acc_start_q;
   logic             res_valid_q;

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others, independent of order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         num_calls_q   <= '0;
         calls_done_q  <= '0;
         cycle_count_q <= '0;
         latency_q     <= '0;
         res_latency_q <= '0;
         acc_arg_q     <= '0;
         res_data_q    <= '0;
         run_busy_q    <= 1'b0;
         run_done_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         arg_ready_q   <= 1'b0;
         acc_start_q   <= 1'b0;
         res_valid_q   <= 1'b0;
      end else begin
         run_done_q <= 1'b0;
         if (run_busy_q) begin
            cycle_count_q <= cycle_count_q + CNT_ONE;
         end

         unique case (state_q)
            S_IDLE: begin
               if (bus.run_start) begin
                  num_calls_q   <= bus.num_calls;
                  calls_done_q  <= '0;
                  cycle_count_q <= '0;
                  timeout_err_q <= 1'b0;
                  run_busy_q    <= 1'b1;
                  if (bus.num_calls == CNT_ZERO) begin
                     state_q <= S_DONE;
                  end else begin
                     arg_ready_q <= 1'b1;
                     state_q     <= S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               if (bus.arg_valid) begin
                  acc_arg_q   <= bus.arg_data;
                  arg_ready_q <= 1'b0;
                  acc_start_q <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end

            // A finish seen here belongs to no call of ours and is dropped.
            S_ISSUE: begin
               if (bus.acc_ready) begin
                  acc_start_q <= 1'b0;
                  latency_q   <= CNT_ONE;
                  state_q     <= S_WAIT;
               end
            end

            // Finish wins over the watchdog when both land on the same cycle.
            S_WAIT: begin
               if (bus.acc_finish) begin
                  res_data_q    <= bus.acc_return_val;
                  res_latency_q <= latency_q;
                  res_valid_q   <= 1'b1;
                  state_q       <= S_EMIT;
               end else if ((TIMEOUT > 0) && (latency_q == WD_LIMIT)) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= S_DONE;
               end else begin
                  latency_q <= latency_q + CNT_ONE;
               end
            end

            S_EMIT: begin
               if (bus.res_ready) begin
                  res_valid_q  <= 1'b0;
                  calls_done_q <= calls_done_q + CNT_ONE;
                  if (calls_done_q + CNT_ONE == num_calls_q) begin
                     state_q <= S_DONE;
                  end else begin
                     arg_ready_q <= 1'b1;
                     state_q     <= S_FETCH;
                  end
               end
            end

            S_DONE: begin
               run_busy_q <= 1'b0;
               run_done_q <= 1'b1;
               state_q    <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   // NOTE: the two handshake-initiating outputs are masked by reset so they fall
   // in the same cycle reset rises, before the synchronous clear takes effect.
   assign bus.acc_start   = acc_start_q & ~reset;
   assign bus.res_valid   = res_valid_q & ~reset;

   assign bus.run_busy    = run_busy_q;
   assign bus.run_done    = run_done_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.arg_ready   = arg_ready_q;
   assign bus.acc_arg     = acc_arg_q;
   assign bus.res_data    = res_data_q;
   assign bus.res_latency = res_latency_q;
   assign bus.calls_done  = calls_done_q;
   assign bus.cycle_count = cycle_count_q;

endmodule
